// File: rtl/gpio_pkg.sv
// Shared definitions for the Wishbone GPIO slave.
// Contents: register byte offsets, the bus FSM state type, the default synchronizer depth
// and a helper that expands byte-lane selects into a bit mask.
package gpio_pkg;

  // Byte offsets within the slot; only address bits [4:2] are decoded.
  localparam logic [4:0] GPIO_OUT_OFF      = 5'h00;
  localparam logic [4:0] GPIO_OEB_OFF      = 5'h04;
  localparam logic [4:0] GPIO_IN_OFF       = 5'h08;
  localparam logic [4:0] GPIO_RISE_EN_OFF  = 5'h0C;
  localparam logic [4:0] GPIO_FALL_EN_OFF  = 5'h10;
  localparam logic [4:0] GPIO_IRQ_STAT_OFF = 5'h14;

  localparam int unsigned GPIO_SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    IDLE,
    RESP
  } bus_state_e;

  // Expand the four byte-lane selects into a 32-bit mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad-input synchronizer with edge detection.
// Ports:
//   i_clk, i_rst    clock and asynchronous active-high reset
//   i_async         raw pad inputs
//   o_sync          inputs after STAGES flops
//   o_rise_raw      sync & ~prev (unqualified rising edges)
//   o_fall_raw      ~sync & prev (unqualified falling edges)
module gpio_sync_edge #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise_raw,
  output logic [WIDTH-1:0] o_fall_raw
);

  // Stage 0 is the first flop after the pad; stage STAGES-1 is the usable value.
  logic [STAGES-1:0][WIDTH-1:0] r_chain;
  logic [WIDTH-1:0]             r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '0;
      r_prev  <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync     = r_chain[STAGES-1];
  assign o_rise_raw = r_chain[STAGES-1] & ~r_prev;
  assign o_fall_raw = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/wishbone_gpio.sv
// Wishbone classic slave for the GPIO slot.
// Every accepted access is answered with a single registered ACK one cycle later, followed by
// a mandatory idle cycle. Drives pad output value/enable, synchronizes pad inputs and raises
// a level interrupt from write-1-to-clear edge status bits.
// Ports:
//   wb_clk_i, wb_rst_i            clock and asynchronous active-high reset
//   wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i   bus request
//   wbs_ack_o, wbs_dat_o          registered response
//   gpio_in                       asynchronous pad inputs
//   gpio_out, gpio_oeb            pad output value and output disable (1 = input)
//   irq_o                         OR of the interrupt status bits
module wishbone_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_PINS    = 32,
  parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oeb,
  output logic                irq_o
);

  // Registers are held only NUM_PINS wide, so bits above the pin count read 0 and drop writes.
  bus_state_e          r_state;
  bus_state_e          w_state_next;
  logic                r_ack;
  logic                w_ack_next;
  logic [31:0]         r_dat;
  logic [31:0]         w_dat_next;
  logic [NUM_PINS-1:0] r_out;
  logic [NUM_PINS-1:0] r_oeb;
  logic [NUM_PINS-1:0] r_rise_en;
  logic [NUM_PINS-1:0] r_fall_en;
  logic [NUM_PINS-1:0] r_irq_stat;

  logic [NUM_PINS-1:0] w_out_next;
  logic [NUM_PINS-1:0] w_oeb_next;
  logic [NUM_PINS-1:0] w_rise_en_next;
  logic [NUM_PINS-1:0] w_fall_en_next;
  logic [NUM_PINS-1:0] w_irq_stat_next;
  logic [NUM_PINS-1:0] w_w1c;

  logic [NUM_PINS-1:0] w_sync;
  logic [NUM_PINS-1:0] w_rise_raw;
  logic [NUM_PINS-1:0] w_fall_raw;

  logic                w_acc;
  logic                w_wr;
  logic [31:0]         w_be;
  logic [NUM_PINS-1:0] w_be_p;
  logic [NUM_PINS-1:0] w_wdat_p;
  logic [2:0]          w_idx;
  logic [NUM_PINS-1:0] w_rdata_p;
  logic [31:0]         w_rdata;

  // Upper address bits and the byte offset are already resolved by the decoder.
  logic w_unused_adr;
  assign w_unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  gpio_sync_edge #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .i_clk      (wb_clk_i),
    .i_rst      (wb_rst_i),
    .i_async    (gpio_in),
    .o_sync     (w_sync),
    .o_rise_raw (w_rise_raw),
    .o_fall_raw (w_fall_raw)
  );

  // Bus FSM: next state and response registers.
  always_comb begin
    w_state_next = r_state;
    w_ack_next   = r_ack;
    w_dat_next   = r_dat;
    w_acc        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          w_acc        = 1'b1;
          w_ack_next   = 1'b1;
          w_dat_next   = wbs_we_i ? 32'h0 : w_rdata;
          w_state_next = RESP;
        end
      end
      RESP: begin
        // The strobe is ignored here, which guarantees an idle cycle between ACKs.
        w_ack_next   = 1'b0;
        w_dat_next   = 32'h0;
        w_state_next = IDLE;
      end
      default: begin
        w_ack_next   = 1'b0;
        w_dat_next   = 32'h0;
        w_state_next = IDLE;
      end
    endcase
  end

  // Register file: write merge, read mux and interrupt status update.
  always_comb begin
    w_wr     = w_acc && wbs_we_i;
    w_be     = sel_to_mask(wbs_sel_i);
    w_be_p   = w_be[NUM_PINS-1:0];
    w_wdat_p = wbs_dat_i[NUM_PINS-1:0];
    w_idx    = wbs_adr_i[4:2];

    w_out_next     = r_out;
    w_oeb_next     = r_oeb;
    w_rise_en_next = r_rise_en;
    w_fall_en_next = r_fall_en;
    w_w1c          = '0;

    if (w_wr) begin
      if (w_idx == GPIO_OUT_OFF[4:2]) begin
        w_out_next = (r_out & ~w_be_p) | (w_wdat_p & w_be_p);
      end
      if (w_idx == GPIO_OEB_OFF[4:2]) begin
        w_oeb_next = (r_oeb & ~w_be_p) | (w_wdat_p & w_be_p);
      end
      if (w_idx == GPIO_RISE_EN_OFF[4:2]) begin
        w_rise_en_next = (r_rise_en & ~w_be_p) | (w_wdat_p & w_be_p);
      end
      if (w_idx == GPIO_FALL_EN_OFF[4:2]) begin
        w_fall_en_next = (r_fall_en & ~w_be_p) | (w_wdat_p & w_be_p);
      end
      if (w_idx == GPIO_IRQ_STAT_OFF[4:2]) begin
        w_w1c = w_wdat_p & w_be_p;
      end
    end

    // OR-ing the new events after the clear makes a coincident hardware set win.
    w_irq_stat_next = (r_irq_stat & ~w_w1c)
                    | (w_rise_raw & r_rise_en)
                    | (w_fall_raw & r_fall_en);

    w_rdata_p = '0;
    case (w_idx)
      GPIO_OUT_OFF[4:2]:      w_rdata_p = r_out;
      GPIO_OEB_OFF[4:2]:      w_rdata_p = r_oeb;
      GPIO_IN_OFF[4:2]:       w_rdata_p = w_sync;
      GPIO_RISE_EN_OFF[4:2]:  w_rdata_p = r_rise_en;
      GPIO_FALL_EN_OFF[4:2]:  w_rdata_p = r_fall_en;
      GPIO_IRQ_STAT_OFF[4:2]: w_rdata_p = r_irq_stat;
      default:                w_rdata_p = '0;
    endcase
    w_rdata                 = '0;
    w_rdata[NUM_PINS-1:0]   = w_rdata_p;
    w_rdata                 = w_rdata & w_be;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_ack      <= 1'b0;
      r_dat      <= 32'h0;
      r_out      <= '0;
      r_oeb      <= '1;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_stat <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ack      <= w_ack_next;
      r_dat      <= w_dat_next;
      r_out      <= w_out_next;
      r_oeb      <= w_oeb_next;
      r_rise_en  <= w_rise_en_next;
      r_fall_en  <= w_fall_en_next;
      r_irq_stat <= w_irq_stat_next;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign gpio_out  = r_out;
  assign gpio_oeb  = r_oeb;
  assign irq_o     = |r_irq_stat;

endmodule

// File: tb/tb_wishbone_gpio.sv
// Directed testbench for wishbone_gpio (NUM_PINS = 32, SYNC_STAGES = 2).
// Inputs are driven 1 time unit after the rising edge and outputs sampled at the same point.
module tb_wishbone_gpio;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr, dat_o;
  logic        ack;
  logic [31:0] gin, gout, goeb;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  logic        a1, a2;
  logic [31:0] rd;

  always #5 clk = ~clk;

  wishbone_gpio #(
    .NUM_PINS    (32),
    .SYNC_STAGES (2)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .gpio_in   (gin),
    .gpio_out  (gout),
    .gpio_oeb  (goeb),
    .irq_o     (irq)
  );

  // One bus transfer; starts and ends 1 unit after a rising edge.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic ack1, output logic [31:0] rdat,
                         output logic ack2);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clk); #1;
    ack1 = ack;
    rdat = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    ack2 = ack;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0; gin = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got %b exp 0", ack); end
    n_cmp++; if (dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat got %h exp 0", dat_o); end
    n_cmp++; if (gout !== 32'h0) begin n_err++; $display("FAIL rst_out got %h exp 0", gout); end
    n_cmp++;
    if (goeb !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL rst_oeb got %h exp ffffffff", goeb);
    end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b exp 0", irq); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wr_idle_ack got %b exp 0", ack); end
    wb_xfer(1'b1, 32'h00, 32'hA5A5_00FF, 4'hF, a1, rd, a2);
    n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL wr_ack got %b exp 1", a1); end
    n_cmp++; if (a2 !== 1'b0) begin n_err++; $display("FAIL wr_ack_drop got %b exp 0", a2); end
    n_cmp++;
    if (gout !== 32'hA5A5_00FF) begin
      n_err++; $display("FAIL wr_gpio_out got %h exp a5a500ff", gout);
    end
    wb_xfer(1'b0, 32'h00, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL rd_ack got %b exp 1", a1); end
    n_cmp++; if (rd !== 32'hA5A5_00FF) begin n_err++; $display("FAIL rd_out got %h exp a5a500ff", rd); end
    n_cmp++; if (a2 !== 1'b0) begin n_err++; $display("FAIL rd_ack_drop got %b exp 0", a2); end
    n_cmp++; if (dat_o !== 32'h0) begin n_err++; $display("FAIL rd_dat_clr got %h exp 0", dat_o); end
  endtask

  task automatic test_byte_lanes();
    wb_xfer(1'b1, 32'h00, 32'h1122_3344, 4'hF, a1, rd, a2);
    wb_xfer(1'b1, 32'h00, 32'hFFFF_FFFF, 4'b0010, a1, rd, a2);
    n_cmp++; if (gout !== 32'h1122_FF44) begin n_err++; $display("FAIL lane_wr got %h exp 1122ff44", gout); end
    wb_xfer(1'b0, 32'h00, 32'h0, 4'b0101, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0022_0044) begin n_err++; $display("FAIL lane_rd got %h exp 00220044", rd); end
    wb_xfer(1'b0, 32'h04, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL oeb_rd got %h exp ffffffff", rd); end
  endtask

  task automatic test_rise_irq();
    wb_xfer(1'b1, 32'h0C, 32'h1, 4'hF, a1, rd, a2);
    gin[0] = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_irq_e0 got %b exp 0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_irq_e1 got %b exp 0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL rise_irq_e2 got %b exp 1", irq); end
    wb_xfer(1'b0, 32'h08, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL rise_in got %h exp 1", rd); end
    wb_xfer(1'b0, 32'h14, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL rise_stat got %h exp 1", rd); end
    wb_xfer(1'b1, 32'h14, 32'h1, 4'hF, a1, rd, a2);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq got %b exp 0", irq); end
    wb_xfer(1'b0, 32'h14, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL w1c_stat got %h exp 0", rd); end
  endtask

  task automatic test_simultaneous();
    gin[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    wb_xfer(1'b1, 32'h10, 32'h4, 4'hF, a1, rd, a2);
    gin[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // This W1C is accepted at the same edge the falling-edge status is set.
    wb_xfer(1'b1, 32'h14, 32'h4, 4'hF, a1, rd, a2);
    n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL sim_ack got %b exp 1", a1); end
    wb_xfer(1'b0, 32'h14, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL sim_stat got %h exp 4", rd); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL sim_irq got %b exp 1", irq); end
    wb_xfer(1'b1, 32'h14, 32'h4, 4'hF, a1, rd, a2);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL sim_clr_irq got %b exp 0", irq); end
  endtask

  task automatic test_unmapped();
    wb_xfer(1'b1, 32'h18, 32'hDEAD_BEEF, 4'hF, a1, rd, a2);
    n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL unm_wr_ack got %b exp 1", a1); end
    wb_xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, a1, rd, a2);
    n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL ro_wr_ack got %b exp 1", a1); end
    wb_xfer(1'b0, 32'h18, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unm_rd18 got %h exp 0", rd); end
    wb_xfer(1'b0, 32'h1C, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unm_rd1c got %h exp 0", rd); end
    wb_xfer(1'b0, 32'h08, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL ro_in got %h exp 1", rd); end
    wb_xfer(1'b0, 32'h00, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h1122_FF44) begin n_err++; $display("FAIL unm_out got %h exp 1122ff44", rd); end
    wb_xfer(1'b0, 32'h0C, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL unm_rise_en got %h exp 1", rd); end
    wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL unm_fall_en got %h exp 4", rd); end
    n_cmp++; if (goeb !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL unm_oeb got %h exp ffffffff", goeb); end
  endtask

  task automatic test_no_strobe();
    cyc = 1'b1; stb = 1'b0; we = 1'b1; adr = 32'h00; dat_i = 32'h0; sel = 4'hF;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL nostb_ack got %b exp 0", ack); end
    cyc = 1'b0; stb = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL nocyc_ack got %b exp 0", ack); end
    n_cmp++; if (gout !== 32'h1122_FF44) begin n_err++; $display("FAIL nostb_out got %h exp 1122ff44", gout); end
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_back_to_back();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0C; sel = 4'hF;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack0 got %b exp 1", ack); end
    n_cmp++; if (dat_o !== 32'h1) begin n_err++; $display("FAIL b2b_dat0 got %h exp 1", dat_o); end
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL b2b_ack1 got %b exp 0", ack); end
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack2 got %b exp 1", ack); end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL b2b_ack3 got %b exp 0", ack); end
  endtask

  task automatic test_reset_mid();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h00; dat_i = 32'h0000_000F; sel = 4'hF;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL rmid_ack got %b exp 1", ack); end
    n_cmp++; if (gout !== 32'hF) begin n_err++; $display("FAIL rmid_out got %h exp f", gout); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rmid_ack_drop got %b exp 0", ack); end
    n_cmp++; if (gout !== 32'h0) begin n_err++; $display("FAIL rmid_out_clr got %h exp 0", gout); end
    n_cmp++; if (goeb !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rmid_oeb got %h exp ffffffff", goeb); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wb_xfer(1'b1, 32'h00, 32'h5, 4'hF, a1, rd, a2);
    n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL post_wr_ack got %b exp 1", a1); end
    wb_xfer(1'b0, 32'h00, 32'h0, 4'hF, a1, rd, a2);
    n_cmp++; if (rd !== 32'h5) begin n_err++; $display("FAIL post_rd got %h exp 5", rd); end
    n_cmp++; if (a2 !== 1'b0) begin n_err++; $display("FAIL post_ack_drop got %b exp 0", a2); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_rise_irq();
    test_simultaneous();
    test_unmapped();
    test_no_strobe();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
